// File: rtl/uart_prog_loader_if.sv
// Memory write port driven by the UART program loader.
// master = loader, slave = target memory bank.
interface uart_prog_loader_if #(
  parameter int NUM_TARGETS = 2,
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 32
);
  logic                   upg_wen_o;
  logic [NUM_TARGETS-1:0] upg_sel_o;
  logic [ADDR_W-1:0]      upg_adr_o;
  logic [DATA_W-1:0]      upg_dat_o;

  modport master (
    output upg_wen_o,
    output upg_sel_o,
    output upg_adr_o,
    output upg_dat_o
  );

  modport slave (
    input upg_wen_o,
    input upg_sel_o,
    input upg_adr_o,
    input upg_dat_o
  );
endinterface

// File: rtl/uart_prog_loader.sv
// UART boot loader: framed 8N1 bytes -> word writes into one of
// several on-chip memories, one status byte back per frame.
module uart_prog_loader #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD         = 128_000,
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int NUM_TARGETS  = 2,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic               upg_clk_i,
  input  logic               upg_rst_i,
  input  logic               upg_rx_i,
  output logic               upg_tx_o,
  output logic               upg_busy_o,
  output logic               upg_done_o,
  uart_prog_loader_if.master upg
);

  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int BPW  = DATA_W / 8;
  localparam int BCW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TMO  = TIMEOUT_BITS * CPB;
  localparam int TW   = $clog2(TMO + 2);
  localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

  localparam logic [7:0] HDR   = 8'hA5;
  localparam logic [7:0] R_OK  = 8'h4F;
  localparam logic [7:0] R_ERR = 8'h45;
  localparam logic [7:0] R_TMO = 8'h54;

  // ---------------- RX ----------------
  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_st_t;

  rx_st_t          rx_st, rx_st_d;
  logic            rx_m, rx_s, rx_p;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_sh;
  logic [7:0]      rx_byte;
  logic            rx_vld;
  logic            rx_ferr;
  logic            rx_fall;
  logic            rx_tick;

  assign rx_fall = rx_p & ~rx_s;
  assign rx_tick = (rx_cnt == CW'(CPB - 1));

  // two-flop synchroniser plus one delay for edge detect
  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
    end else begin
      rx_m <= upg_rx_i;
      rx_s <= rx_m;
      rx_p <= rx_s;
    end
  end

  // receiver sequencing: start check, 8 data bits, stop bit
  always_comb begin
    rx_st_d = rx_st;
    unique case (rx_st)
      R_IDLE:  if (rx_fall) rx_st_d = R_START;
      R_START: if (rx_cnt == CW'(HALF - 1))
                 rx_st_d = rx_s ? R_IDLE : R_DATA;
      R_DATA:  if (rx_tick && rx_bit == 3'd7)
                 rx_st_d = R_STOP;
      R_STOP:  if (rx_tick) rx_st_d = R_IDLE;
      default: rx_st_d = R_IDLE;
    endcase
  end

  // receiver state, bit timing and byte capture
  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      rx_st   <= R_IDLE;
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
      rx_byte <= '0;
      rx_vld  <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      rx_st  <= rx_st_d;
      rx_vld <= 1'b0;
      if (rx_st == R_IDLE || rx_st != rx_st_d ||
          (rx_st == R_DATA && rx_tick))
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 1'b1;
      if (rx_st == R_START)
        rx_bit <= '0;
      if (rx_st == R_DATA && rx_tick) begin
        rx_sh  <= {rx_s, rx_sh[7:1]};
        rx_bit <= rx_bit + 1'b1;
      end
      if (rx_st == R_STOP && rx_tick) begin
        rx_vld  <= 1'b1;
        rx_byte <= rx_sh;
        rx_ferr <= ~rx_s;
      end
    end
  end

  // ---------------- main FSM ----------------
  typedef enum logic [2:0] {
    S_IDLE, S_TGT, S_LEN0, S_LEN1,
    S_DATA, S_CSUM, S_RESP, S_DONE
  } st_t;

  st_t               st, st_d;
  logic [7:0]        code_d;
  logic              set_done;
  logic              put_word;
  logic [15:0]       len_d;
  logic [DATA_W-1:0] word_d;
  logic              tmo_hit;

  logic [7:0]        csum;
  logic [6:0]        tgt_q;
  logic              last_q;
  logic [7:0]        len_lo;
  logic [15:0]       len_q;
  logic [15:0]       wcnt;
  logic [ADDR_W-1:0] adr_q;
  logic [BCW-1:0]    bcnt;
  logic [DATA_W-1:0] word_q;
  logic [TW-1:0]     tmo_q;
  logic [7:0]        resp_q;
  logic              tx_go;
  logic              tx_done;
  logic              done_q;

  assign upg_done_o = done_q;
  assign upg_busy_o = (st != S_IDLE) && (st != S_DONE);
  assign len_d      = {rx_byte, len_lo};
  assign tmo_hit    = (tmo_q == TW'(TMO));

  // byte k of the word lands in bits [8k+7:8k]
  always_comb begin
    word_d = word_q;
    word_d[{bcnt, 3'b000} +: 8] = rx_byte;
  end

  // next state and per-byte decisions
  always_comb begin
    st_d     = st;
    code_d   = R_ERR;
    set_done = 1'b0;
    put_word = 1'b0;
    unique case (st)
      S_IDLE:
        if (rx_vld && !rx_ferr && rx_byte == HDR)
          st_d = S_TGT;
      S_RESP:
        if (tx_done)
          st_d = done_q ? S_DONE : S_IDLE;
      S_DONE: ;
      default: begin
        if (rx_vld && rx_ferr) begin
          st_d = S_RESP;
        end else if (tmo_hit) begin
          st_d   = S_RESP;
          code_d = R_TMO;
        end else if (rx_vld) begin
          unique case (st)
            S_TGT:
              st_d = (rx_byte[6:0] >= 7'(NUM_TARGETS))
                     ? S_RESP : S_LEN0;
            S_LEN0:
              st_d = S_LEN1;
            S_LEN1:
              if ({17'd0, len_d} > DEPTH) st_d = S_RESP;
              else if (len_d == 16'd0)    st_d = S_CSUM;
              else                        st_d = S_DATA;
            S_DATA:
              if (bcnt == BCW'(BPW - 1)) begin
                put_word = 1'b1;
                if (wcnt == len_q - 16'd1) st_d = S_CSUM;
              end
            S_CSUM: begin
              st_d = S_RESP;
              if (rx_byte == csum) begin
                code_d   = R_OK;
                set_done = last_q;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // state register, frame datapath and write port
  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      st            <= S_IDLE;
      csum          <= '0;
      tgt_q         <= '0;
      last_q        <= 1'b0;
      len_lo        <= '0;
      len_q         <= '0;
      wcnt          <= '0;
      adr_q         <= '0;
      bcnt          <= '0;
      word_q        <= '0;
      tmo_q         <= '0;
      resp_q        <= '0;
      tx_go         <= 1'b0;
      done_q        <= 1'b0;
      upg.upg_wen_o <= 1'b0;
      upg.upg_sel_o <= '0;
      upg.upg_adr_o <= '0;
      upg.upg_dat_o <= '0;
    end else begin
      st    <= st_d;
      tx_go <= (st_d == S_RESP) && (st != S_RESP);
      if (st_d == S_RESP && st != S_RESP)
        resp_q <= code_d;
      if (set_done)
        done_q <= 1'b1;

      upg.upg_wen_o <= put_word;
      upg.upg_sel_o <= put_word
                       ? (NUM_TARGETS'(1) << tgt_q) : '0;
      if (put_word) begin
        upg.upg_dat_o <= word_d;
        upg.upg_adr_o <= adr_q;
        adr_q         <= adr_q + 1'b1;
        wcnt          <= wcnt + 1'b1;
      end

      if (st == S_IDLE && st_d == S_TGT)
        csum <= '0;
      else if (rx_vld && (st == S_TGT || st == S_LEN0 ||
                          st == S_LEN1 || st == S_DATA))
        csum <= csum ^ rx_byte;

      if (rx_vld) begin
        unique case (st)
          S_TGT: begin
            tgt_q  <= rx_byte[6:0];
            last_q <= rx_byte[7];
          end
          S_LEN0: len_lo <= rx_byte;
          S_LEN1: begin
            len_q <= len_d;
            adr_q <= '0;
            wcnt  <= '0;
            bcnt  <= '0;
          end
          S_DATA: begin
            word_q <= word_d;
            bcnt   <= (bcnt == BCW'(BPW - 1))
                      ? '0 : bcnt + 1'b1;
          end
          default: ;
        endcase
      end

      if (st == S_TGT || st == S_LEN0 || st == S_LEN1 ||
          st == S_DATA || st == S_CSUM)
        tmo_q <= rx_vld ? '0 : tmo_q + 1'b1;
      else
        tmo_q <= '0;
    end
  end

  // ---------------- TX ----------------
  logic          tx_act;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_frm;

  // status byte shifter: start, 8 data bits LSB first, stop
  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      upg_tx_o <= 1'b1;
      tx_act   <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_frm   <= '0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (tx_go) begin
        tx_frm   <= {1'b1, resp_q};
        upg_tx_o <= 1'b0;
        tx_cnt   <= '0;
        tx_bit   <= '0;
        tx_act   <= 1'b1;
      end else if (tx_act) begin
        if (tx_cnt == CW'(CPB - 1)) begin
          tx_cnt <= '0;
          if (tx_bit == 4'd9) begin
            tx_act   <= 1'b0;
            tx_done  <= 1'b1;
            upg_tx_o <= 1'b1;
          end else begin
            upg_tx_o <= tx_frm[tx_bit];
            tx_bit   <= tx_bit + 1'b1;
          end
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader at 16 clocks per bit.
// Decodes TX, logs write strobes, checks with immediate asserts.
module tb_uart_prog_loader;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx;
  logic busy;
  logic done;

  uart_prog_loader_if #(
    .NUM_TARGETS(2), .ADDR_W(4), .DATA_W(32)
  ) bus ();

  uart_prog_loader #(
    .CLK_HZ(16), .BAUD(1), .ADDR_W(4), .DATA_W(32),
    .NUM_TARGETS(2), .TIMEOUT_BITS(64)
  ) dut (
    .upg_clk_i (clk),
    .upg_rst_i (rst),
    .upg_rx_i  (rx),
    .upg_tx_o  (tx),
    .upg_busy_o(busy),
    .upg_done_o(done),
    .upg       (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  txq[$];
  logic [1:0]  wsel[$];
  logic [3:0]  wadr[$];
  logic [31:0] wdat[$];
  logic [31:0] words[$];

  // log every cycle the write strobe is high
  always @(negedge clk) begin
    if (bus.upg_wen_o === 1'b1) begin
      wsel.push_back(bus.upg_sel_o);
      wadr.push_back(bus.upg_adr_o);
      wdat.push_back(bus.upg_dat_o);
    end
  end

  // decode status bytes coming back on tx
  always begin
    logic [7:0] b;
    @(negedge clk);
    if (tx === 1'b0) begin
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      txq.push_back(b);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b,
                      input logic stopb = 1'b1);
    rx = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(CPB);
    end
    rx = stopb;
    cyc(CPB);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] tgt,
                            input logic bad);
    logic [15:0] n;
    logic [7:0]  cs;
    logic [7:0]  b;
    n  = 16'(words.size());
    cs = tgt ^ n[7:0] ^ n[15:8];
    send(8'hA5);
    send(tgt);
    send(n[7:0]);
    send(n[15:8]);
    foreach (words[i]) begin
      for (int k = 0; k < 4; k++) begin
        b  = words[i][8*k +: 8];
        cs = cs ^ b;
        send(b);
      end
    end
    send(bad ? ~cs : cs);
  endtask

  task automatic wait_tx(input string tag,
                         input logic [7:0] exp);
    logic [8:0] got;
    int t;
    t = 0;
    while (txq.size() == 0 && t < 3000) begin
      cyc(1);
      t++;
    end
    got = (txq.size() == 0) ? 9'h100 : {1'b0, txq.pop_front()};
    chk(tag, 32'(got), 32'(exp));
    cyc(20);
  endtask

  task automatic chk_wr(input string tag,
                        input logic [1:0] s,
                        input logic [3:0] a,
                        input logic [31:0] d);
    logic [1:0]  os;
    logic [3:0]  oa;
    logic [31:0] od;
    os = 'x;
    oa = 'x;
    od = 'x;
    if (wsel.size() > 0) begin
      os = wsel.pop_front();
      oa = wadr.pop_front();
      od = wdat.pop_front();
    end
    chk({tag, "_sel"}, 32'(os), 32'(s));
    chk({tag, "_adr"}, 32'(oa), 32'(a));
    chk({tag, "_dat"}, od, d);
  endtask

  task automatic clear_logs();
    txq.delete();
    wsel.delete();
    wadr.delete();
    wdat.delete();
  endtask

  initial begin
    // reset values
    cyc(5);
    chk("rst_tx",   32'(tx), 32'd1);
    chk("rst_wen",  32'(bus.upg_wen_o), 32'd0);
    chk("rst_sel",  32'(bus.upg_sel_o), 32'd0);
    chk("rst_adr",  32'(bus.upg_adr_o), 32'd0);
    chk("rst_dat",  bus.upg_dat_o, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    cyc(10);

    // 8-cycle glitch, then a frame right behind it
    rx = 1'b0;
    cyc(8);
    rx = 1'b1;
    cyc(4);
    chk("glitch_busy", 32'(busy), 32'd0);
    words = '{32'hA1B2C3D4};
    send_frame(8'h00, 1'b0);
    wait_tx("glitch_resp", 8'h4F);
    chk("glitch_nwr", 32'(wadr.size()), 32'd1);
    chk_wr("glitch_w0", 2'b01, 4'd0, 32'hA1B2C3D4);
    chk("glitch_done", 32'(done), 32'd0);

    // three words, corrupted checksum
    words = '{32'h11111111, 32'h22222222, 32'h33333333};
    send_frame(8'h00, 1'b1);
    wait_tx("badcs_resp", 8'h45);
    chk("badcs_nwr", 32'(wadr.size()), 32'd3);
    chk_wr("badcs_w0", 2'b01, 4'd0, 32'h11111111);
    chk_wr("badcs_w1", 2'b01, 4'd1, 32'h22222222);
    chk_wr("badcs_w2", 2'b01, 4'd2, 32'h33333333);
    chk("badcs_done", 32'(done), 32'd0);
    chk("badcs_busy", 32'(busy), 32'd0);

    // good frame afterwards, target 1
    words = '{32'hCAFEBABE, 32'h0BADF00D};
    send_frame(8'h01, 1'b0);
    wait_tx("retry_resp", 8'h4F);
    chk("retry_nwr", 32'(wadr.size()), 32'd2);
    chk_wr("retry_w0", 2'b10, 4'd0, 32'hCAFEBABE);
    chk_wr("retry_w1", 2'b10, 4'd1, 32'h0BADF00D);

    // target index out of range
    send(8'hA5);
    send(8'h05);
    wait_tx("badtgt_resp", 8'h45);
    chk("badtgt_nwr", 32'(wadr.size()), 32'd0);

    // LEN = DEPTH + 1 = 17
    send(8'hA5);
    send(8'h00);
    send(8'h11);
    send(8'h00);
    wait_tx("biglen_resp", 8'h45);
    chk("biglen_nwr", 32'(wadr.size()), 32'd0);

    // LEN = 0, checksum = TGT
    send(8'hA5);
    send(8'h01);
    send(8'h00);
    send(8'h00);
    send(8'h01);
    wait_tx("len0_resp", 8'h4F);
    chk("len0_nwr", 32'(wadr.size()), 32'd0);
    chk("len0_done", 32'(done), 32'd0);

    // sender stalls after two data bytes
    send(8'hA5);
    send(8'h00);
    send(8'h01);
    send(8'h00);
    send(8'h10);
    send(8'h20);
    chk("tmo_busy", 32'(busy), 32'd1);
    cyc(65 * CPB);
    wait_tx("tmo_resp", 8'h54);
    chk("tmo_nwr", 32'(wadr.size()), 32'd0);

    // framing error mid-frame
    send(8'hA5);
    send(8'h00);
    send(8'h01);
    send(8'h00);
    send(8'h12, 1'b0);
    wait_tx("ferr_resp", 8'h45);
    chk("ferr_nwr", 32'(wadr.size()), 32'd0);

    // reset in the middle of DATA
    send(8'hA5);
    send(8'h00);
    send(8'h02);
    send(8'h00);
    send(8'hEF);
    send(8'hBE);
    send(8'hAD);
    send(8'hDE);
    send(8'h55);
    rx = 1'b0;
    cyc(8);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_dat", bus.upg_dat_o, 32'hDEADBEEF);
    rst = 1'b1;
    cyc(1);
    chk("mrst_tx",   32'(tx), 32'd1);
    chk("mrst_wen",  32'(bus.upg_wen_o), 32'd0);
    chk("mrst_sel",  32'(bus.upg_sel_o), 32'd0);
    chk("mrst_adr",  32'(bus.upg_adr_o), 32'd0);
    chk("mrst_dat",  bus.upg_dat_o, 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    rx = 1'b1;
    cyc(4);
    rst = 1'b0;
    chk("mrst_nwr", 32'(wadr.size()), 32'd1);
    clear_logs();
    cyc(10);

    // final LAST frame, hand-computed checksum 0x88
    send(8'hA5);
    send(8'h81);
    send(8'h01);
    send(8'h00);
    send(8'h78);
    send(8'h56);
    send(8'h34);
    send(8'h12);
    send(8'h88);
    wait_tx("last_resp", 8'h4F);
    chk("last_nwr", 32'(wadr.size()), 32'd1);
    chk_wr("last_w0", 2'b10, 4'd0, 32'h12345678);
    chk("last_done", 32'(done), 32'd1);
    chk("last_busy", 32'(busy), 32'd0);

    // DONE ignores everything
    words = '{32'h01020304};
    send_frame(8'h00, 1'b0);
    cyc(200);
    chk("done_nwr", 32'(wadr.size()), 32'd0);
    chk("done_ntx", 32'(txq.size()), 32'd0);
    chk("done_hold", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
